// File: rtl/board_eval.sv
// Board evaluator: walks num_boards 64-square boards in SDRAM, computes a signed
// material score per board, writes it to a score array and tracks the best board.
module board_eval (
  input  logic        clk,
  input  logic        rst,
  // CPU-facing Avalon-MM slave
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  // SDRAM-facing Avalon-MM master
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata,
  // FSM state for observation
  output logic [2:0]  dbg_state
);

  // Master handshake: a request (read or write) is held with a stable address
  // until master_waitrequest is low at a rising edge; read data is taken on the
  // first cycle master_readdatavalid is high, with at most one read in flight.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_SQ    = 3'd1,
    WT_SQ    = 3'd2,
    ACC      = 3'd3,
    WR_SCORE = 3'd4,
    NEXT     = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam logic [31:0] ADDR_IDLE  = 32'hFFFF_FFFF;
  localparam logic [31:0] SCORE_MIN  = 32'h8000_0000;
  localparam logic [31:0] BOARD_SIZE = 32'd256;

  state_t      state;
  logic [31:0] board_base;
  logic [31:0] num_boards;
  logic [31:0] score_base;
  logic [31:0] best_idx;
  logic [31:0] best_score;
  logic [31:0] acc;
  logic [5:0]  sq;
  logic [31:0] board_idx;
  logic [31:0] board_addr;
  logic [7:0]  piece;
  logic        busy;
  logic        done;

  logic [7:0]  piece_mag;
  logic [31:0] piece_val;
  logic [31:0] piece_sval;
  logic [31:0] acc_sum;
  logic [31:0] next_sq_addr;
  logic [31:0] score_addr;
  logic        last_board;
  logic        status_rd;
  logic        unused_bits;

  assign slave_waitrequest = 1'b0;
  assign dbg_state         = state;
  assign unused_bits       = ^master_readdata[31:8];

  // Codes are two's complement; -128 yields magnitude 128 and scores zero.
  assign piece_mag = piece[7] ? (8'd0 - piece) : piece;

  always_comb begin
    piece_val = 32'd0;
    case (piece_mag)
      8'd1:    piece_val = 32'd100;
      8'd2:    piece_val = 32'd320;
      8'd3:    piece_val = 32'd330;
      8'd4:    piece_val = 32'd500;
      8'd5:    piece_val = 32'd900;
      8'd6:    piece_val = 32'd20000;
      default: piece_val = 32'd0;
    endcase
  end

  assign piece_sval   = piece[7] ? (32'd0 - piece_val) : piece_val;
  assign acc_sum      = acc + piece_sval;
  assign next_sq_addr = board_addr + {24'd0, sq + 6'd1, 2'b00};
  assign score_addr   = score_base + {board_idx[29:0], 2'b00};
  assign last_board   = (board_idx == num_boards - 32'd1);
  assign status_rd    = slave_read && (slave_address == 4'd0);

  always_comb begin
    slave_readdata = 32'd0;
    case (slave_address)
      4'd0:    slave_readdata = {30'd0, done, busy};
      4'd1:    slave_readdata = best_idx;
      4'd2:    slave_readdata = best_score;
      default: slave_readdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      board_base       <= ADDR_IDLE;
      num_boards       <= 32'd0;
      score_base       <= ADDR_IDLE;
      best_idx         <= ADDR_IDLE;
      best_score       <= SCORE_MIN;
      acc              <= 32'd0;
      sq               <= 6'd0;
      board_idx        <= 32'd0;
      board_addr       <= 32'd0;
      piece            <= 8'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      master_read      <= 1'b0;
      master_write     <= 1'b0;
      master_address   <= ADDR_IDLE;
      master_writedata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (slave_write) begin
            case (slave_address)
              4'd1: board_base <= slave_writedata;
              4'd2: num_boards <= slave_writedata;
              4'd3: score_base <= slave_writedata;
              4'd0: begin
                acc        <= 32'd0;
                sq         <= 6'd0;
                board_idx  <= 32'd0;
                board_addr <= board_base;
                best_idx   <= ADDR_IDLE;
                best_score <= SCORE_MIN;
                if (num_boards == 32'd0) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  state          <= RD_SQ;
                  busy           <= 1'b1;
                  master_read    <= 1'b1;
                  master_address <= board_base;
                end
              end
              default: ;
            endcase
          end
        end

        RD_SQ: begin
          if (!master_waitrequest) begin
            master_read    <= 1'b0;
            master_address <= ADDR_IDLE;
            state          <= WT_SQ;
          end
        end

        WT_SQ: begin
          if (master_readdatavalid) begin
            piece <= master_readdata[7:0];
            state <= ACC;
          end
        end

        ACC: begin
          acc <= acc_sum;
          if (sq == 6'd63) begin
            state            <= WR_SCORE;
            master_write     <= 1'b1;
            master_address   <= score_addr;
            master_writedata <= acc_sum;
          end else begin
            sq             <= sq + 6'd1;
            state          <= RD_SQ;
            master_read    <= 1'b1;
            master_address <= next_sq_addr;
          end
        end

        WR_SCORE: begin
          if (!master_waitrequest) begin
            master_write     <= 1'b0;
            master_address   <= ADDR_IDLE;
            master_writedata <= 32'd0;
            state            <= NEXT;
          end
        end

        NEXT: begin
          // Strict compare: a tie keeps the earlier board.
          if ($signed(acc) > $signed(best_score)) begin
            best_score <= acc;
            best_idx   <= board_idx;
          end
          board_idx  <= board_idx + 32'd1;
          board_addr <= board_addr + BOARD_SIZE;
          acc        <= 32'd0;
          sq         <= 6'd0;
          if (last_board) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state          <= RD_SQ;
            master_read    <= 1'b1;
            master_address <= board_addr + BOARD_SIZE;
          end
        end

        DONE: begin
          if (status_rd) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_eval.sv
// Bench for board_eval: an SDRAM model with programmable wait/valid delays,
// a table of board runs, and directed sequences for latency, reset and busy cases.
module tb_board_eval;

  logic        clk = 1'b0;
  logic        rst;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;
  logic [2:0]  dbg_state;

  board_eval dut (
    .clk                  (clk),
    .rst                  (rst),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata),
    .dbg_state            (dbg_state)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NEG900 = 32'hFFFF_FC7C;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mem [0:4095];
  int          max_delay = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  bit          rd_pending = 0;
  int          rd_delay = 0;
  logic [31:0] rd_addr;
  bit          req_seen = 0;
  int          wait_left = 0;
  bit          stall_prev = 0;
  logic [31:0] stall_addr;
  logic [31:0] stall_data;
  logic [1:0]  stall_rw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory side, acceptance: sampled at the rising edge before DUT updates land.
  always @(posedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      check("rd_wr_exclusive", {31'd0, master_read & master_write}, 32'd0);
      if (stall_prev) begin
        check("stall_rw_hold", {30'd0, master_read, master_write}, {30'd0, stall_rw});
        check("stall_addr_hold", master_address, stall_addr);
        if (stall_rw[0]) check("stall_data_hold", master_writedata, stall_data);
      end
      stall_prev = (master_read || master_write) && master_waitrequest;
      stall_rw   = {master_read, master_write};
      stall_addr = master_address;
      stall_data = master_writedata;
      if (master_read && !master_waitrequest) begin
        check("one_outstanding", {31'd0, rd_pending}, 32'd0);
        rd_pending = 1;
        rd_addr    = master_address;
        rd_delay   = $urandom_range(max_delay, 0);
        rd_count++;
        req_seen   = 0;
      end
      if (master_write && !master_waitrequest) begin
        mem[master_address[13:2]] = master_writedata;
        wr_count++;
        req_seen = 0;
      end
    end
  end

  // Memory side, responses: driven at the falling edge.
  always @(negedge clk) begin
    master_readdatavalid = 1'b0;
    master_readdata      = $urandom;
    if (rd_pending) begin
      if (rd_delay == 0) begin
        master_readdatavalid = 1'b1;
        master_readdata      = mem[rd_addr[13:2]];
        rd_pending           = 0;
      end else begin
        rd_delay--;
      end
    end
    if (master_read || master_write) begin
      if (!req_seen) begin
        req_seen  = 1;
        wait_left = $urandom_range(max_delay, 0);
      end
      if (wait_left > 0) begin
        master_waitrequest = 1'b1;
        wait_left--;
      end else begin
        master_waitrequest = 1'b0;
      end
    end else begin
      req_seen           = 0;
      master_waitrequest = 1'b0;
    end
  end

  task automatic slv_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_address   = a;
    slave_writedata = d;
    slave_write     = 1'b1;
    @(negedge clk);
    slave_write     = 1'b0;
  endtask

  task automatic slv_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    slave_address = a;
    slave_read    = 1'b1;
    #1 d = slave_readdata;
    @(negedge clk);
    slave_read    = 1'b0;
  endtask

  // Side-effect-free look at the combinational read mux.
  task automatic peek(input logic [3:0] a, output logic [31:0] d);
    slave_address = a;
    #1 d = slave_readdata;
  endtask

  task automatic wait_done(input string name);
    logic [31:0] st;
    bit ok;
    ok = 0;
    st = 32'd0;
    for (int c = 0; c < 20000 && !ok; c++) begin
      slv_rd(4'd0, st);
      if (st[1]) ok = 1;
    end
    check({name, "_done_seen"}, {31'd0, ok}, 32'd1);
    check({name, "_done_status"}, st, 32'd2);
  endtask

  function automatic logic [7:0] code_at(input int kind, input int sq);
    int x;
    int y;
    logic [7:0] back;
    logic [7:0] c;
    x = sq % 8;
    y = sq / 8;
    case (x)
      0, 7:    back = 8'd4;
      1, 6:    back = 8'd2;
      2, 5:    back = 8'd3;
      3:       back = 8'd5;
      default: back = 8'd6;
    endcase
    c = 8'd0;
    if (kind == 3) begin
      case (sq)
        0:       c = 8'd7;
        1:       c = 8'hF8;
        2:       c = 8'h80;
        59:      c = 8'hFB;
        default: c = 8'd0;
      endcase
    end else begin
      if (y == 0)      c = back;
      else if (y == 1) c = 8'd1;
      else if (y == 6) c = 8'hFF;
      else if (y == 7) c = 8'd0 - back;
      if (kind == 1 && sq == 48) c = 8'd0;
      if (kind == 2 && sq == 59) c = 8'd0;
    end
    return c;
  endfunction

  task automatic setup_mem(input int n, input logic [5:0] kinds);
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    for (int i = 0; i < 4; i++) mem[12'h800 + i] = 32'hDEAD_BEEF;
    for (int b = 0; b < n; b++)
      for (int s = 0; s < 64; s++)
        mem[12'h400 + 64 * b + s] = {24'hC0FFEE, code_at(int'(kinds[2*b +: 2]), s)};
  endtask

  task automatic program_and_start(input logic [31:0] n);
    slv_wr(4'd1, 32'h1000);
    slv_wr(4'd2, n);
    slv_wr(4'd3, 32'h2000);
    slv_wr(4'd0, 32'd0);
  endtask

  // kinds: 2 bits per board (board 0 in the low bits); exp: 32 bits per board.
  typedef struct packed {
    logic [1:0]  n;
    logic [5:0]  kinds;
    logic [2:0]  dly;
    logic [95:0] exp;
    logic [31:0] bidx;
    logic [31:0] bscore;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [31:0] d;
    int wr0;
    int rd0;
    int cyc;
    bit hit;

    rst = 1'b1;
    slave_address = 4'd0;
    slave_read = 1'b0;
    slave_write = 1'b0;
    slave_writedata = 32'd0;
    master_waitrequest = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata = 32'd0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;

    vecs[0] = '{n: 2'd1, kinds: {2'd0, 2'd0, 2'd0}, dly: 3'd0,
                exp: {32'd0, 32'd0, 32'd0}, bidx: 32'd0, bscore: 32'd0};
    vecs[1] = '{n: 2'd3, kinds: {2'd2, 2'd2, 2'd1}, dly: 3'd0,
                exp: {32'd900, 32'd900, 32'd100}, bidx: 32'd1, bscore: 32'd900};
    vecs[2] = '{n: 2'd3, kinds: {2'd2, 2'd2, 2'd1}, dly: 3'd5,
                exp: {32'd900, 32'd900, 32'd100}, bidx: 32'd1, bscore: 32'd900};
    vecs[3] = '{n: 2'd1, kinds: {2'd0, 2'd0, 2'd3}, dly: 3'd2,
                exp: {32'd0, 32'd0, NEG900}, bidx: 32'd0, bscore: NEG900};
    vecs[4] = '{n: 2'd2, kinds: {2'd0, 2'd0, 2'd3}, dly: 3'd3,
                exp: {32'd0, 32'd0, NEG900}, bidx: 32'd1, bscore: 32'd0};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_master_read", {31'd0, master_read}, 32'd0);
    check("rst_master_write", {31'd0, master_write}, 32'd0);
    check("rst_master_addr", master_address, 32'hFFFF_FFFF);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    check("rst_waitrequest", {31'd0, slave_waitrequest}, 32'd0);
    peek(4'd0, d); check("rst_status", d, 32'd0);
    peek(4'd1, d); check("rst_best_idx", d, 32'hFFFF_FFFF);
    peek(4'd2, d); check("rst_best_score", d, 32'h8000_0000);
    peek(4'd3, d); check("rst_addr3", d, 32'd0);
    rst = 1'b0;

    // Table-driven board runs
    for (int v = 0; v < 5; v++) begin
      setup_mem(int'(vecs[v].n), vecs[v].kinds);
      max_delay = int'(vecs[v].dly);
      wr0 = wr_count;
      program_and_start({30'd0, vecs[v].n});
      wait_done($sformatf("vec%0d", v));
      for (int b = 0; b < int'(vecs[v].n); b++)
        check($sformatf("vec%0d_score%0d", v, b), mem[12'h800 + b], vecs[v].exp[32*b +: 32]);
      check($sformatf("vec%0d_no_extra", v), mem[12'h800 + int'(vecs[v].n)], 32'hDEAD_BEEF);
      check($sformatf("vec%0d_wr_count", v), wr_count - wr0, {30'd0, vecs[v].n});
      slv_rd(4'd1, d); check($sformatf("vec%0d_best_idx", v), d, vecs[v].bidx);
      slv_rd(4'd2, d); check($sformatf("vec%0d_best_score", v), d, vecs[v].bscore);
      slv_rd(4'd0, d); check($sformatf("vec%0d_idle_status", v), d, 32'd0);
    end

    // Minimum latency with zero-wait memory
    setup_mem(1, 6'd0);
    max_delay = 0;
    program_and_start(32'd1);
    cyc = 0;
    while (dbg_state != 3'd6 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("latency_cycles", cyc, 32'd194);
    slv_rd(4'd0, d); check("latency_done", d, 32'd2);
    check("latency_back_idle", {29'd0, dbg_state}, 32'd0);

    // num_boards = 0 finishes immediately with no master traffic
    rd0 = rd_count;
    wr0 = wr_count;
    slv_wr(4'd2, 32'd0);
    slv_wr(4'd0, 32'd0);
    check("zero_state_done", {29'd0, dbg_state}, 32'd6);
    peek(4'd1, d); check("zero_best_idx", d, 32'hFFFF_FFFF);
    peek(4'd2, d); check("zero_best_score", d, 32'h8000_0000);
    slv_rd(4'd0, d); check("zero_status", d, 32'd2);
    check("zero_rd_traffic", rd_count - rd0, 32'd0);
    check("zero_wr_traffic", wr_count - wr0, 32'd0);
    check("zero_back_idle", {29'd0, dbg_state}, 32'd0);

    // Register writes ignored while busy
    setup_mem(1, {2'd0, 2'd0, 2'd3});
    max_delay = 1;
    program_and_start(32'd1);
    slv_rd(4'd0, d); check("busy_status", d, 32'd1);
    slv_wr(4'd1, 32'h3000);
    wait_done("busy1");
    check("busy1_score", mem[12'h800], NEG900);
    mem[12'h800] = 32'hDEAD_BEEF;
    slv_wr(4'd0, 32'd0);
    wait_done("busy2");
    check("busy2_score_same_base", mem[12'h800], NEG900);
    slv_rd(4'd2, d); check("busy2_best_score", d, NEG900);

    // Reset mid-operation at square 30 of board 1, then a fresh run
    setup_mem(2, {2'd0, 2'd2, 2'd1});
    max_delay = 0;
    program_and_start(32'd2);
    hit = 0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      @(negedge clk);
      #1;
      if (master_read && master_address == 32'h1178) hit = 1;
    end
    check("rst_mid_reached", {31'd0, hit}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_read_drop", {31'd0, master_read}, 32'd0);
    check("rst_mid_write_low", {31'd0, master_write}, 32'd0);
    check("rst_mid_state", {29'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    peek(4'd0, d); check("rst_mid_status", d, 32'd0);
    peek(4'd1, d); check("rst_mid_best_idx", d, 32'hFFFF_FFFF);
    peek(4'd2, d); check("rst_mid_best_score", d, 32'h8000_0000);
    repeat (4) @(negedge clk);
    mem[12'h800] = 32'hDEAD_BEEF;
    mem[12'h801] = 32'hDEAD_BEEF;
    program_and_start(32'd2);
    wait_done("rst_fresh");
    check("rst_fresh_score0", mem[12'h800], 32'd100);
    check("rst_fresh_score1", mem[12'h801], 32'd900);
    slv_rd(4'd1, d); check("rst_fresh_best_idx", d, 32'd1);
    slv_rd(4'd2, d); check("rst_fresh_best_score", d, 32'd900);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/board_eval.md
BOARD_EVAL -- requirements
Module: board_eval

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have an Avalon-MM slave (CPU-facing) with these ports: slave_waitrequest out 1; slave_address in 4; slave_read in 1; slave_readdata out 32; slave_write in 1; slave_writedata in 32.
REQ-004 SHALL have an Avalon-MM master (SDRAM-facing) with these ports: master_waitrequest in 1; master_address out 32; master_read out 1; master_readdata in 32; master_readdatavalid in 1; master_write out 1; master_writedata out 32.
REQ-005 SHALL map slave write registers as follows: addr 1 = board_base; addr 2 = num_boards; addr 3 = score_base; addr 0 = start (data ignored).
REQ-006 SHALL map slave reads as follows: addr 0 = status {30'b0, done, busy}; addr 1 = best_idx; addr 2 = best_score; any other address reads 0.

Function
REQ-007 SHALL consume the board arrays written by the pawn move generator: each board is 64 words, square (x,y) at base + 4*(8*y+x), and the signed piece code is in bits [7:0].
REQ-008 SHALL place board i at board_base + 256*i, for i = 0..num_boards-1.
REQ-009 SHALL value pieces by code magnitude: 1=100, 2=320, 3=330, 4=500, 5=900, 6=20000; magnitude 0, 7 or more SHALL contribute 0.
REQ-010 SHALL compute the board score as the signed 32-bit sum of +value for positive codes and -value for negative codes.
REQ-011 SHALL use the states IDLE, RD_SQ, WT_SQ, ACC, WR_SCORE, NEXT, DONE.
REQ-012 SHALL transition IDLE->RD_SQ on a slave write to addr 0, clearing the accumulator, square counter, board counter, best_idx = 32'hFFFFFFFF and best_score = 32'h80000000.
REQ-013 SHALL transition IDLE->DONE instead when num_boards == 0 at start.
REQ-014 SHALL, in RD_SQ, assert master_read with master_address = board address of the current square, holding both stable until master_waitrequest == 0, then go to WT_SQ.
REQ-015 SHALL wait in WT_SQ until master_readdatavalid, registering bits [7:0], then go to ACC; only one read SHALL be outstanding.
REQ-016 SHALL, in ACC, add the value to the accumulator; square 63 SHALL go to WR_SCORE, otherwise the square counter increments and the FSM returns to RD_SQ.
REQ-017 SHALL, in WR_SCORE, assert master_write with master_address = score_base + 4*i and master_writedata = the accumulator, holding until master_waitrequest == 0, then go to NEXT.
REQ-018 SHALL, in NEXT, update best_score/best_idx only if score > best_score (strict signed compare, so ties keep the lower index), then increment i and clear the accumulator and square counter.
REQ-019 SHALL leave NEXT for DONE if i == num_boards-1, else for RD_SQ.
REQ-020 SHALL, in DONE, hold done = 1 and return to IDLE on a slave read of addr 0, that read returning done = 1.
REQ-021 SHALL keep best_idx and best_score readable after the return to IDLE until the next start.
REQ-022 SHALL assert busy in RD_SQ, WT_SQ, ACC, WR_SCORE and NEXT.
REQ-023 SHALL ignore slave writes to any address while busy or DONE; register writes SHALL be accepted only in IDLE.
REQ-024 SHALL keep slave_waitrequest at 0 at all times; slave_readdata SHALL be combinational from registers.
REQ-025 SHALL never assert master_read and master_write together; outside RD_SQ/WR_SCORE both SHALL be 0, master_address = 32'hFFFFFFFF and master_writedata = 0.
REQ-026 SHALL have a minimum latency per board, with zero-wait memory and readdatavalid one cycle after acceptance, of 64*3+2 = 194 cycles.
REQ-027 SHALL use wrapping 32-bit address arithmetic, with no overflow detection.

Reset
REQ-028 SHALL, while rst is high, force state = IDLE and master_read = master_write = 0 immediately, without waiting for a clock edge.
REQ-029 SHALL, on reset, set board_base = score_base = 32'hFFFFFFFF, num_boards = 0, best_idx = 32'hFFFFFFFF, best_score = 32'h80000000, accumulator = 0, busy = done = 0.
REQ-030 SHALL, on reset mid-operation, abandon the outstanding read or write and ignore any later readdatavalid while in IDLE.

Verification
REQ-031 SHALL be verified for the initial position: board_base = 0x1000, num_boards = 1, score_base = 0x2000, start -> word 0 at 0x2000, value 0; best_idx = 0; best_score = 0; done = 1.
REQ-032 SHALL be verified for three boards scoring +100, +900, +900 -> score array {100, 900, 900}; best_idx = 1 (tie keeps the lower index); best_score = 900.
REQ-033 SHALL be verified for num_boards = 0 -> DONE within 1 cycle; no master traffic; best_idx = 0xFFFFFFFF; best_score = 0x80000000.
REQ-034 SHALL be verified with random master_waitrequest and readdatavalid delays of 0-5 cycles: scores equal the zero-delay run, address/read stay stable during waitrequest, and there is never more than one outstanding read.
REQ-035 SHALL be verified with rst asserted at square 30 of board 1 -> master_read drops the same cycle; registers take reset values; a fresh start then completes correctly.
REQ-036 SHALL be verified with codes 7, -8 and 0 on a board otherwise holding only a black queen (-5) -> score -900; a write to addr 1 during busy leaves board_base unchanged.
